// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, fetch FSM states
// and the registered fetch output bundle.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_RET,
    ST_HALTED,
    ST_ERROR
  } fetch_state_e;

  typedef struct packed {
    logic        f_valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pc;
    stat_e       stat;
  } fetch_out_t;

  localparam fetch_out_t FETCH_BUBBLE = '{
    f_valid: 1'b0, icode: I_NOP, ifun: 4'h0, ra: REG_NONE, rb: REG_NONE,
    valc: 64'h0, valp: 64'h0, pc: 64'h0, stat: STAT_AOK
  };

  // Undefined icodes count as one byte so the address check still has a span.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
      I_JXX, I_CALL:                    instr_len = 4'd9;
      default:                          instr_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/y86_fetch_if.sv
// Fetch-stage control, instruction-memory load port and decode-facing outputs.
interface y86_fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [7:0]  imem_wdata;
  logic        f_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] pc_out;
  logic [2:0]  stat;

  modport master (
    output stall, redirect_valid, redirect_pc, imem_we, imem_addr, imem_wdata,
    input  f_valid, icode, ifun, rA, rB, valC, valP, pc_out, stat
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_we, imem_addr, imem_wdata,
    output f_valid, icode, ifun, rA, rB, valC, valP, pc_out, stat
  );
endinterface

// File: rtl/y86_fetch_instr_split.sv
// Combinational splitter for one Y86-64 instruction starting at pc_i.
// Define FETCH_IFUN_CHECK_EN to reject function codes undefined for their icode.
module instr_split
  import y86_pkg::*;
(
  input  logic [7:0]  bytes_i [10],
  input  logic [63:0] pc_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [63:0] valc_o,
  output logic [63:0] valp_o,
  output logic        need_regs_o,
  output logic        need_valc_o,
  output logic [3:0]  length_o,
  output logic        instr_valid_o
);

  logic ifun_ok;

  assign icode_o  = bytes_i[0][7:4];
  assign ifun_o   = bytes_i[0][3:0];
  assign length_o = instr_len(icode_o);
  assign valp_o   = pc_i + 64'(length_o);

  assign need_regs_o = icode_o inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                       I_OPQ, I_PUSHQ, I_POPQ};
  assign need_valc_o = icode_o inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};

  assign ra_o = need_regs_o ? bytes_i[1][7:4] : REG_NONE;
  assign rb_o = need_regs_o ? bytes_i[1][3:0] : REG_NONE;

  // The constant follows the register byte when there is one.
  always_comb begin
    valc_o = 64'h0;
    if (need_valc_o) begin
      for (int k = 0; k < 8; k++) begin
        valc_o[8*k +: 8] = need_regs_o ? bytes_i[k+2] : bytes_i[k+1];
      end
    end
  end

`ifdef FETCH_IFUN_CHECK_EN
  always_comb begin
    case (icode_o)
      I_OPQ:           ifun_ok = (ifun_o <= 4'd3);
      I_JXX, I_RRMOVQ: ifun_ok = (ifun_o <= 4'd6);
      default:         ifun_ok = (ifun_o == 4'd0);
    endcase
  end
`else
  assign ifun_ok = 1'b1;
`endif

  assign instr_valid_o = (icode_o <= I_POPQ) && ifun_ok;

endmodule

// File: rtl/y86_fetch.sv
// Y86-64 fetch stage: PC register, byte-wide instruction memory, next-PC
// prediction and the run/wait-ret/halt/error sequencer (see instr_split for FETCH_IFUN_CHECK_EN).
module y86_fetch
  import y86_pkg::*;
#(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic     clk,
  input  logic     rst_n,
  y86_fetch_if.slave fif
);

  localparam int          AW       = $clog2(IMEM_BYTES);
  localparam logic [63:0] MEM_SIZE = 64'(IMEM_BYTES);

  logic [7:0]   mem_q [IMEM_BYTES];
  logic [7:0]   ibytes [10];
  logic [63:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;
  fetch_out_t   out_q, out_d, fetched;

  logic [3:0]  sp_icode, sp_ifun, sp_ra, sp_rb, sp_len;
  logic [63:0] sp_valc, sp_valp, last_addr;
  logic        sp_need_regs, sp_need_valc, sp_valid, adr_fault, jump_like;
  stat_e       fetch_stat;

  // NOTE: the memory array is deliberately not reset; its contents are defined
  // only by the load port, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (fif.imem_we && (fif.imem_addr < MEM_SIZE)) begin
      mem_q[fif.imem_addr[AW-1:0]] <= fif.imem_wdata;
    end
  end

  // Bytes past the end of memory read as zero; the address check flags them anyway.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      ibytes[k] = ((pc_q + 64'(k)) < MEM_SIZE) ? mem_q[AW'(pc_q + 64'(k))] : 8'h00;
    end
  end

  instr_split u_split (
    .bytes_i       (ibytes),
    .pc_i          (pc_q),
    .icode_o       (sp_icode),
    .ifun_o        (sp_ifun),
    .ra_o          (sp_ra),
    .rb_o          (sp_rb),
    .valc_o        (sp_valc),
    .valp_o        (sp_valp),
    .need_regs_o   (sp_need_regs),
    .need_valc_o   (sp_need_valc),
    .length_o      (sp_len),
    .instr_valid_o (sp_valid)
  );

  // Only jXX and call carry a constant without a register byte.
  assign jump_like = sp_need_valc && !sp_need_regs;
  assign last_addr = pc_q + 64'(sp_len) - 64'd1;
  assign adr_fault = (pc_q >= MEM_SIZE) || (last_addr >= MEM_SIZE);

  always_comb begin
    if (adr_fault)                 fetch_stat = STAT_ADR;
    else if (!sp_valid)            fetch_stat = STAT_INS;
    else if (sp_icode == I_HALT)   fetch_stat = STAT_HLT;
    else                           fetch_stat = STAT_AOK;
  end

  assign fetched = '{f_valid: 1'b1, icode: sp_icode, ifun: sp_ifun, ra: sp_ra,
                     rb: sp_rb, valc: sp_valc, valp: sp_valp, pc: pc_q,
                     stat: fetch_stat};

  // NOTE: every next-state signal gets its hold value first, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    case (state_q)
      ST_RUN, ST_WAIT_RET: begin
        if (fif.redirect_valid) begin
          pc_d    = fif.redirect_pc;
          state_d = ST_RUN;
          out_d   = FETCH_BUBBLE;
        end else if (fif.stall) begin
          // hold PC, state and outputs
        end else if (state_q == ST_WAIT_RET) begin
          out_d = FETCH_BUBBLE;
        end else begin
          out_d = fetched;
          case (fetch_stat)
            STAT_ADR, STAT_INS: state_d = ST_ERROR;
            STAT_HLT:           state_d = ST_HALTED;
            default: begin
              if (sp_icode == I_RET) state_d = ST_WAIT_RET;
              pc_d = jump_like ? sp_valc : sp_valp;
            end
          endcase
        end
      end
      default: out_d = FETCH_BUBBLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      out_q   <= FETCH_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  assign fif.f_valid = out_q.f_valid;
  assign fif.icode   = out_q.icode;
  assign fif.ifun    = out_q.ifun;
  assign fif.rA      = out_q.ra;
  assign fif.rB      = out_q.rb;
  assign fif.valC    = out_q.valc;
  assign fif.valP    = out_q.valp;
  assign fif.pc_out  = out_q.pc;
  assign fif.stat    = out_q.stat;

endmodule

// File: tb/tb_y86_fetch.sv
// Self-checking bench for y86_fetch: directed scenarios plus a randomized program
// run against an instruction-level reference model.
module tb_y86_fetch;

  localparam int N = 1024;

  typedef struct packed {
    logic        f_valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pc;
    logic [2:0]  stat;
  } obs_t;

  localparam obs_t BUBBLE = '{1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 3'd1};
  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2, M_ERR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  y86_fetch_if fif ();
  y86_fetch #(.IMEM_BYTES(N), .RESET_PC(64'h0)) dut (.clk(clk), .rst_n(rst_n), .fif(fif));

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  tmem [N];
  logic [63:0] m_pc;
  int          m_mode;
  obs_t        exp_o;
  int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

  function automatic obs_t get_obs();
    return '{fif.f_valid, fif.icode, fif.ifun, fif.rA, fif.rB,
             fif.valC, fif.valP, fif.pc_out, fif.stat};
  endfunction

  function automatic logic [7:0] rd(input logic [63:0] a);
    return (a < 64'(N)) ? tmem[int'(a[31:0])] : 8'h00;
  endfunction

  // Instruction-level reference: what the decode stage should see next cycle.
  task automatic model_step(input bit st, input bit rv, input logic [63:0] rpc);
    logic [7:0]  b0;
    logic [3:0]  ic, fn;
    logic [63:0] valc, len;
    bit          ok, regs, hasc, adr;
    if (m_mode == M_HALT || m_mode == M_ERR) begin
      exp_o = BUBBLE;
    end else if (rv) begin
      m_pc = rpc; m_mode = M_RUN; exp_o = BUBBLE;
    end else if (st) begin
      // nothing changes
    end else if (m_mode == M_WAIT) begin
      exp_o = BUBBLE;
    end else begin
      b0 = rd(m_pc); ic = b0[7:4]; fn = b0[3:0];
      ok = (ic <= 4'hB);
`ifdef FETCH_IFUN_CHECK_EN
      if (ic == 4'h6) ok = (fn <= 4'd3);
      else if (ic == 4'h7 || ic == 4'h2) ok = (fn <= 4'd6);
      else if (ok) ok = (fn == 4'd0);
`endif
      len  = 64'(len_tab[ic]);
      regs = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
      hasc = ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
      valc = 64'h0;
      if (hasc)
        for (int k = 0; k < 8; k++) valc[8*k +: 8] = rd(m_pc + (regs ? 64'd2 : 64'd1) + 64'(k));
      adr = (m_pc >= 64'(N)) || (m_pc + len - 64'd1 >= 64'(N));
      exp_o = '{1'b1, ic, fn, regs ? b0_hi(rd(m_pc + 1)) : 4'hF,
                regs ? b0_lo(rd(m_pc + 1)) : 4'hF, valc, m_pc + len, m_pc,
                adr ? 3'd3 : !ok ? 3'd4 : (ic == 4'h0) ? 3'd2 : 3'd1};
      if (adr || !ok)          m_mode = M_ERR;
      else if (ic == 4'h0)     m_mode = M_HALT;
      else if (ic == 4'h9)     m_mode = M_WAIT;
      else if (ic == 4'h7 || ic == 4'h8) m_pc = valc;
      else                     m_pc = m_pc + len;
    end
  endtask

  function automatic logic [3:0] b0_hi(input logic [7:0] b); return b[7:4]; endfunction
  function automatic logic [3:0] b0_lo(input logic [7:0] b); return b[3:0]; endfunction

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic tick(input bit st, input bit rv, input logic [63:0] rpc);
    fif.stall = st; fif.redirect_valid = rv; fif.redirect_pc = rpc;
    model_step(st, rv, rpc);
    @(posedge clk); #1;
    fif.stall = 1'b0; fif.redirect_valid = 1'b0;
  endtask

  task automatic load_byte(input logic [63:0] a, input logic [7:0] d);
    fif.imem_we = 1'b1; fif.imem_addr = a; fif.imem_wdata = d;
    tmem[int'(a[31:0])] = d;
    @(posedge clk); #1;
    fif.imem_we = 1'b0;
  endtask

  task automatic load_instr(input logic [63:0] a, input logic [79:0] v, input int n);
    for (int k = 0; k < n; k++) load_byte(a + 64'(k), v[8*k +: 8]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    m_pc = 64'h0; m_mode = M_RUN; exp_o = BUBBLE;
  endtask

  task automatic test_reset();
    obs_t o;
    do_reset();
    o = get_obs(); n_cmp++;
    if (o !== BUBBLE) begin n_err++; $display("FAIL reset_values: got %h want %h", o, BUBBLE); end
  endtask

  task automatic test_irmovq();
    obs_t o, e;
    do_reset();
    load_instr(64'h0, 80'h0000_0000_0000_0123_F030, 10);
    rst_n = 1'b1;
    tick(0, 0, 0);
    e = '{1'b1, 4'h3, 4'h0, 4'hF, 4'h0, 64'h123, 64'd10, 64'h0, 3'd1};
    o = get_obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL irmovq: got %h want %h", o, e); end
  endtask

  task automatic test_jump();
    obs_t o, e;
    do_reset();
    load_instr(64'h10, 80'h0000_0000_0000_0000_4070, 9);
    load_instr(64'h40, 80'h10, 1);
    rst_n = 1'b1;
    tick(0, 1, 64'h10);
    o = get_obs(); n_cmp++;
    if (o !== BUBBLE) begin n_err++; $display("FAIL jump_redirect_bubble: got %h want %h", o, BUBBLE); end
    tick(0, 0, 0);
    e = '{1'b1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h19, 64'h10, 3'd1};
    o = get_obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL jxx_fields: got %h want %h", o, e); end
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.icode, o.pc} !== {1'b1, 4'h1, 64'h40})
      begin n_err++; $display("FAIL jxx_target: got pc %h icode %h want pc 40 icode 1", o.pc, o.icode); end
  endtask

  task automatic test_ret();
    obs_t o, e;
    do_reset();
    load_instr(64'h20, 80'h90, 1);
    load_instr(64'h80, 80'h10, 1);
    rst_n = 1'b1;
    tick(0, 1, 64'h20);
    tick(0, 0, 0);
    e = '{1'b1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 64'h20, 3'd1};
    o = get_obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL ret_fields: got %h want %h", o, e); end
    for (int i = 0; i < 3; i++) begin
      tick(i == 1, 0, 0);
      o = get_obs(); n_cmp++;
      if ({o.f_valid, o.icode} !== {1'b0, 4'h1})
        begin n_err++; $display("FAIL ret_wait_bubble: got v=%b ic=%h want v=0 ic=1", o.f_valid, o.icode); end
    end
    tick(0, 1, 64'h80);
    o = get_obs(); n_cmp++;
    if (o.f_valid !== 1'b0) begin n_err++; $display("FAIL ret_redirect_bubble: got v=%b want 0", o.f_valid); end
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.pc} !== {1'b1, 64'h80})
      begin n_err++; $display("FAIL ret_resume: got v=%b pc=%h want v=1 pc=80", o.f_valid, o.pc); end
  endtask

  task automatic test_halt();
    obs_t o, e;
    do_reset();
    load_instr(64'h30, 80'h00, 1);
    rst_n = 1'b1;
    tick(0, 1, 64'h30);
    tick(0, 0, 0);
    e = '{1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h31, 64'h30, 3'd2};
    o = get_obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL halt_fields: got %h want %h", o, e); end
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 64'h80);
      o = get_obs(); n_cmp++;
      if ({o.f_valid, o.icode} !== {1'b0, 4'h1})
        begin n_err++; $display("FAIL halt_ignores_redirect: got v=%b ic=%h want v=0 ic=1", o.f_valid, o.icode); end
    end
  endtask

  task automatic test_adr();
    obs_t o;
    do_reset();
    load_instr(64'(N - 4), 80'h0123_F030, 4);
    rst_n = 1'b1;
    tick(0, 1, 64'(N - 4));
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.stat, o.pc} !== {1'b1, 3'd3, 64'(N - 4)})
      begin n_err++; $display("FAIL adr_irmovq: got v=%b stat=%0d pc=%h want v=1 stat=3", o.f_valid, o.stat, o.pc); end
    tick(0, 1, 64'h80);
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if (o.f_valid !== 1'b0) begin n_err++; $display("FAIL adr_error_sticky: got v=%b want 0", o.f_valid); end
    // OPq ending exactly on the last byte is legal; the next PC is not.
    do_reset();
    load_instr(64'(N - 2), 80'h1260, 2);
    rst_n = 1'b1;
    tick(0, 1, 64'(N - 2));
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.icode, o.ra, o.rb, o.stat, o.valp} !== {1'b1, 4'h6, 4'h1, 4'h2, 3'd1, 64'(N)})
      begin n_err++; $display("FAIL adr_last_fit: got v=%b ic=%h stat=%0d valP=%h want stat=1 valP=%h", o.f_valid, o.icode, o.stat, o.valp, N); end
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.stat, o.pc} !== {1'b1, 3'd3, 64'(N)})
      begin n_err++; $display("FAIL adr_pc_at_end: got v=%b stat=%0d pc=%h want stat=3", o.f_valid, o.stat, o.pc); end
    do_reset();
    rst_n = 1'b1;
    tick(0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.stat, o.pc} !== {1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8})
      begin n_err++; $display("FAIL adr_high_pc: got v=%b stat=%0d pc=%h want stat=3", o.f_valid, o.stat, o.pc); end
  endtask

  task automatic test_ins();
    obs_t o;
    do_reset();
    load_instr(64'h50, 80'hC0, 1);
    rst_n = 1'b1;
    tick(0, 1, 64'h50);
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.icode, o.stat, o.pc} !== {1'b1, 4'hC, 3'd4, 64'h50})
      begin n_err++; $display("FAIL ins_c0: got v=%b ic=%h stat=%0d want v=1 ic=c stat=4", o.f_valid, o.icode, o.stat); end
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if (o.f_valid !== 1'b0) begin n_err++; $display("FAIL ins_then_error: got v=%b want 0", o.f_valid); end
  endtask

  task automatic test_stall();
    obs_t o, e_irm, e_op;
    do_reset();
    load_instr(64'h0, 80'h0000_0000_0000_0123_F030, 10);
    load_instr(64'd10, 80'h1260, 2);
    load_instr(64'h40, 80'h10, 1);
    rst_n = 1'b1;
    tick(0, 0, 0);
    e_irm = '{1'b1, 4'h3, 4'h0, 4'hF, 4'h0, 64'h123, 64'd10, 64'h0, 3'd1};
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      o = get_obs(); n_cmp++;
      if (o !== e_irm) begin n_err++; $display("FAIL stall_hold: got %h want %h", o, e_irm); end
    end
    tick(0, 0, 0);
    e_op = '{1'b1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'd12, 64'd10, 3'd1};
    o = get_obs(); n_cmp++;
    if (o !== e_op) begin n_err++; $display("FAIL stall_release: got %h want %h", o, e_op); end
    tick(1, 1, 64'h40);
    o = get_obs(); n_cmp++;
    if (o !== BUBBLE) begin n_err++; $display("FAIL stall_redirect_bubble: got %h want %h", o, BUBBLE); end
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.pc} !== {1'b1, 64'h40})
      begin n_err++; $display("FAIL stall_redirect_wins: got v=%b pc=%h want pc=40", o.f_valid, o.pc); end
  endtask

  task automatic test_write_read();
    obs_t o;
    do_reset();
    load_instr(64'h0, 80'h1010, 2);
    rst_n = 1'b1;
    fif.imem_we = 1'b1; fif.imem_addr = 64'h0; fif.imem_wdata = 8'h00;
    tick(0, 0, 0);
    fif.imem_we = 1'b0; tmem[0] = 8'h00;
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.icode, o.stat} !== {1'b1, 4'h1, 3'd1})
      begin n_err++; $display("FAIL write_read_old: got ic=%h stat=%0d want ic=1 stat=1", o.icode, o.stat); end
    tick(0, 1, 64'h0);
    tick(0, 0, 0);
    o = get_obs(); n_cmp++;
    if ({o.f_valid, o.icode, o.stat} !== {1'b1, 4'h0, 3'd2})
      begin n_err++; $display("FAIL write_took_effect: got ic=%h stat=%0d want ic=0 stat=2", o.icode, o.stat); end
  endtask

  task automatic test_random();
    logic [63:0] starts[$];
    logic [79:0] v;
    logic [63:0] a, valc;
    logic [3:0]  ic, fn;
    int          off;
    bit          st, rv;
    obs_t        o;
    int          ics [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    do_reset();
    a = 64'h0;
    while (a < 64'd200) begin
      ic = 4'(ics[$urandom_range(0, 10)]);
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) :
           (ic == 4'h2 || ic == 4'h7) ? 4'($urandom_range(0, 6)) : 4'h0;
      starts.push_back(a);
      v = '0;
      v[7:0] = {ic, fn};
      if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) v[15:8] = 8'($urandom);
      valc = (ic == 4'h7 || ic == 4'h8) ? starts[$urandom_range(0, starts.size() - 1)]
                                        : {32'($urandom), 32'($urandom)};
      off = (ic inside {4'h3, 4'h4, 4'h5}) ? 2 : 1;
      if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) v[8*off +: 64] = valc;
      load_instr(a, v, len_tab[ic]);
      a = a + 64'(len_tab[ic]);
    end
    starts.push_back(a);
    load_instr(a, 80'h70, 9);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 3) == 0);
      rv = (m_mode == M_WAIT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      tick(st, rv, starts[$urandom_range(0, starts.size() - 1)]);
      o = get_obs(); n_cmp++;
      if (o !== exp_o) begin n_err++; $display("FAIL random_c%0d: got %h want %h", c, o, exp_o); end
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    #3 rst_n = 1'b0;
    #1;
    o = get_obs(); n_cmp++;
    if (o !== BUBBLE) begin n_err++; $display("FAIL async_reset: got %h want %h", o, BUBBLE); end
    @(posedge clk); #1;
  endtask

  initial begin
    fif.stall = 1'b0; fif.redirect_valid = 1'b0; fif.redirect_pc = 64'h0;
    fif.imem_we = 1'b0; fif.imem_addr = 64'h0; fif.imem_wdata = 8'h0;
    for (int i = 0; i < N; i++) tmem[i] = 8'h00;
    #1;
    test_reset();
    test_irmovq();
    test_jump();
    test_ret();
    test_halt();
    test_adr();
    test_ins();
    test_stall();
    test_write_read();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
